// File: rtl/alu_pkg.sv
// alu_pkg: encodings shared between the execute stage and the control unit.
//   - SEL_* : aluSel functional-unit codes (6 and 7 are reserved)
//   - state_e : execute-stage FSM states
//   - op_e  : decoded sub-operation, resolved from aluSel plus is* strobes
//   - decode_op : applies the per-unit strobe priority
package alu_pkg;

  localparam logic [2:0] SEL_ADD   = 3'd0;
  localparam logic [2:0] SEL_MUL   = 3'd1;
  localparam logic [2:0] SEL_DIV   = 3'd2;
  localparam logic [2:0] SEL_MOV   = 3'd3;
  localparam logic [2:0] SEL_LOGIC = 3'd4;
  localparam logic [2:0] SEL_SHIFT = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_CMP  = 4'd3,
    OP_MUL  = 4'd4,
    OP_DIV  = 4'd5,
    OP_MOD  = 4'd6,
    OP_AND  = 4'd7,
    OP_OR   = 4'd8,
    OP_NOT  = 4'd9,
    OP_MOV  = 4'd10,
    OP_LSL  = 4'd11,
    OP_LSR  = 4'd12,
    OP_ASR  = 4'd13
  } op_e;

  // Strobes only count inside the selected unit; within a unit the
  // earlier strobe wins. Anything unmatched (or a reserved sel) is OP_NONE,
  // which completes without touching result or flags.
  function automatic op_e decode_op(
    input logic [2:0] sel,
    input logic is_add, input logic is_sub, input logic is_cmp,
    input logic is_mul, input logic is_div, input logic is_mod,
    input logic is_and, input logic is_or,  input logic is_not,
    input logic is_mov, input logic is_lsl, input logic is_lsr,
    input logic is_asr
  );
    op_e op;
    op = OP_NONE;
    case (sel)
      SEL_ADD: begin
        if (is_add)      op = OP_ADD;
        else if (is_sub) op = OP_SUB;
        else if (is_cmp) op = OP_CMP;
      end
      SEL_MUL: begin
        if (is_mul) op = OP_MUL;
      end
      SEL_DIV: begin
        if (is_div)      op = OP_DIV;
        else if (is_mod) op = OP_MOD;
      end
      SEL_MOV: begin
        if (is_mov) op = OP_MOV;
      end
      SEL_LOGIC: begin
        if (is_and)      op = OP_AND;
        else if (is_or)  op = OP_OR;
        else if (is_not) op = OP_NOT;
      end
      SEL_SHIFT: begin
        if (is_lsl)      op = OP_LSL;
        else if (is_lsr) op = OP_LSR;
        else if (is_asr) op = OP_ASR;
      end
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (aborts a division)
//   start_i       : load dividend/divisor and begin WIDTH iterations
//   dividend_i    : numerator, sampled with start_i
//   divisor_i     : denominator (must be nonzero), sampled with start_i
//   busy_o        : iterations in progress
//   done_o        : high during the final iteration; quotient_o and
//                   remainder_o are final after that clock edge and hold
//                   until the next start_i
//   quotient_o    : quotient
//   remainder_o   : remainder
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] quo_q;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    cnt_q;
  logic             active_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Since rem_q < divisor, trial < 2*divisor, so the sign bit of the
  // (WIDTH+1)-bit difference is exactly "divisor does not fit".
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvsr_q};
    fits  = ~diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      quo_q    <= dividend_i;
      rem_q    <= '0;
      dvsr_q   <= divisor_i;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], fits};
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        active_q <= 1'b0;
      end
    end
  end

  assign busy_o      = active_q;
  assign done_o      = active_q && (cnt_q == CNT_LAST);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage. Single-cycle add/sub/cmp, mov, logic and
// shift; iterative multiply (inline shift-add) and divide/modulo
// (seq_divider), all finishing through a one-cycle DONE state.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   go              : start strobe, only honoured in IDLE
//   aluSel          : functional unit select (alu_pkg::SEL_*)
//   is*             : sub-operation strobes, captured with go
//   op1, op2        : operands, captured with go
//   result          : result register, holds between operations
//   flagE, flagGt   : compare flags, written only by Cmp
//   busy            : iterative operation in progress
//   done            : one-cycle pulse when result/flags are final
//   divZero         : last Div/Mod had a zero divisor; cleared on next go
//   dbg_state       : current FSM state (alu_pkg::state_e encoding)
//
// Handshake: go is a request sampled at a rising edge while the unit is in
// IDLE; any go outside IDLE is dropped, not queued. Every accepted go yields
// exactly one done pulse (unless rst intervenes), and go may be raised again
// during the done cycle for back-to-back operation.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [2:0]       aluSel,
  input  logic             isAdd,
  input  logic             isSub,
  input  logic             isCmp,
  input  logic             isMul,
  input  logic             isDiv,
  input  logic             isMod,
  input  logic             isAnd,
  input  logic             isOr,
  input  logic             isNot,
  input  logic             isMov,
  input  logic             isLsl,
  input  logic             isLsr,
  input  logic             isAsr,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] result,
  output logic             flagE,
  output logic             flagGt,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [WIDTH-1:0] result_q;
  logic             flag_e_q;
  logic             flag_gt_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;
  logic             dz_pend_q;      // captured op had sel=DIV and op2==0

  // Inline multiplier: accumulator, left-shifting multiplicand,
  // right-shifting multiplier.
  logic [WIDTH-1:0] mul_acc_q;
  logic [WIDTH-1:0] mul_mcand_q;
  logic [WIDTH-1:0] mul_mplier_q;
  logic [SHW-1:0]   mul_cnt_q;

  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  logic [WIDTH-1:0] result_d;
  logic             flag_e_d;
  logic             flag_gt_d;
  logic [SHW-1:0]   shamt;
  logic signed [WIDTH-1:0] op1_s;

  // The divider loads straight from the input operands on the accepting
  // edge, so its WIDTH iterations line up with the DIV state.
  assign div_start = (state_q == IDLE) && go && (aluSel == SEL_DIV) &&
                     (op2 != '0);

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .dividend_i  (op1),
    .divisor_i   (op2),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Final value computed in DONE from the captured operands / unit results.
  always_comb begin
    result_d  = result_q;
    flag_e_d  = flag_e_q;
    flag_gt_d = flag_gt_q;
    shamt     = op2_q[SHW-1:0];
    op1_s     = op1_q;
    case (op_q)
      OP_ADD: result_d = op1_q + op2_q;
      OP_SUB: result_d = op1_q - op2_q;
      OP_CMP: begin
        flag_e_d  = (op1_q == op2_q);
        flag_gt_d = ($signed(op1_q) > $signed(op2_q));
      end
      OP_MUL: result_d = mul_acc_q;
      OP_DIV: result_d = dz_pend_q ? '1 : div_quo;
      OP_MOD: result_d = dz_pend_q ? op1_q : div_rem;
      OP_AND: result_d = op1_q & op2_q;
      OP_OR:  result_d = op1_q | op2_q;
      OP_NOT: result_d = ~op2_q;
      OP_MOV: result_d = op2_q;
      OP_LSL: result_d = op1_q << shamt;
      OP_LSR: result_d = op1_q >> shamt;
      OP_ASR: result_d = op1_s >>> shamt;
      default: result_d = result_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_NONE;
      op1_q        <= '0;
      op2_q        <= '0;
      result_q     <= '0;
      flag_e_q     <= 1'b0;
      flag_gt_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      div_zero_q   <= 1'b0;
      dz_pend_q    <= 1'b0;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      // Registered from the current state: high after each iterating edge,
      // already low on the edge that raises done.
      busy_q <= (state_q == MUL) || (state_q == DIV);
      case (state_q)
        IDLE: begin
          if (go) begin
            op1_q        <= op1;
            op2_q        <= op2;
            op_q         <= decode_op(aluSel, isAdd, isSub, isCmp, isMul,
                                      isDiv, isMod, isAnd, isOr, isNot,
                                      isMov, isLsl, isLsr, isAsr);
            div_zero_q   <= 1'b0;
            dz_pend_q    <= (aluSel == SEL_DIV) && (op2 == '0);
            mul_acc_q    <= '0;
            mul_mcand_q  <= op1;
            mul_mplier_q <= op2;
            mul_cnt_q    <= '0;
            if (aluSel == SEL_MUL) begin
              state_q <= MUL;
            end else if ((aluSel == SEL_DIV) && (op2 != '0)) begin
              state_q <= DIV;
            end else begin
              state_q <= DONE;
            end
          end
        end
        MUL: begin
          if (mul_mplier_q[0]) begin
            mul_acc_q <= mul_acc_q + mul_mcand_q;
          end
          mul_mcand_q  <= mul_mcand_q << 1;
          mul_mplier_q <= mul_mplier_q >> 1;
          mul_cnt_q    <= mul_cnt_q + 1'b1;
          if (mul_cnt_q == CNT_LAST) begin
            state_q <= DONE;
          end
        end
        DIV: begin
          if (div_done || !div_busy) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          result_q  <= result_d;
          flag_e_q  <= flag_e_d;
          flag_gt_q <= flag_gt_d;
          done_q    <= 1'b1;
          if (dz_pend_q && ((op_q == OP_DIV) || (op_q == OP_MOD))) begin
            div_zero_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result    = result_q;
  assign flagE     = flag_e_q;
  assign flagGt    = flag_gt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign divZero   = div_zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int W = 32;

  // Strobe vector bit order: {isAdd,isSub,isCmp,isMul,isDiv,isMod,isAnd,
  //                           isOr,isNot,isMov,isLsl,isLsr,isAsr}
  localparam logic [12:0] S_ADD = 13'h1000;
  localparam logic [12:0] S_SUB = 13'h0800;
  localparam logic [12:0] S_CMP = 13'h0400;
  localparam logic [12:0] S_MUL = 13'h0200;
  localparam logic [12:0] S_DIV = 13'h0100;
  localparam logic [12:0] S_MOD = 13'h0080;
  localparam logic [12:0] S_AND = 13'h0040;
  localparam logic [12:0] S_OR  = 13'h0020;
  localparam logic [12:0] S_NOT = 13'h0010;
  localparam logic [12:0] S_MOV = 13'h0008;
  localparam logic [12:0] S_LSL = 13'h0004;
  localparam logic [12:0] S_LSR = 13'h0002;
  localparam logic [12:0] S_ASR = 13'h0001;

  localparam logic [2:0] U_ADD = 3'd0;
  localparam logic [2:0] U_MUL = 3'd1;
  localparam logic [2:0] U_DIV = 3'd2;
  localparam logic [2:0] U_MOV = 3'd3;
  localparam logic [2:0] U_LOG = 3'd4;
  localparam logic [2:0] U_SHF = 3'd5;

  logic          clk;
  logic          rst;
  logic          go;
  logic [2:0]    aluSel;
  logic          isAdd, isSub, isCmp, isMul, isDiv, isMod;
  logic          isAnd, isOr, isNot, isMov, isLsl, isLsr, isAsr;
  logic [W-1:0]  op1, op2;
  logic [W-1:0]  result;
  logic          flagE, flagGt, busy, done, divZero;
  logic [1:0]    dbg_state;

  int            n_checks;
  int            n_fail;
  logic [W-1:0]  exp_q[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .aluSel    (aluSel),
    .isAdd     (isAdd),
    .isSub     (isSub),
    .isCmp     (isCmp),
    .isMul     (isMul),
    .isDiv     (isDiv),
    .isMod     (isMod),
    .isAnd     (isAnd),
    .isOr      (isOr),
    .isNot     (isNot),
    .isMov     (isMov),
    .isLsl     (isLsl),
    .isLsr     (isLsr),
    .isAsr     (isAsr),
    .op1       (op1),
    .op2       (op2),
    .result    (result),
    .flagE     (flagE),
    .flagGt    (flagGt),
    .busy      (busy),
    .done      (done),
    .divZero   (divZero),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_strobes(input logic [12:0] s);
    {isAdd, isSub, isCmp, isMul, isDiv, isMod, isAnd, isOr, isNot,
     isMov, isLsl, isLsr, isAsr} = s;
  endtask

  // Issue one operation, wait for done within a bounded budget, check the
  // latency and the result against the expected queue. If poke > 0, a
  // spurious MOV go is held across the poke-th edge after acceptance.
  task automatic run_op(input string tag, input logic [2:0] sel,
                        input logic [12:0] s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input int exp_lat, input int poke);
    int   cyc;
    bit   seen;
    logic busy_first;
    exp_q.push_back(exp_res);
    aluSel = sel;
    set_strobes(s);
    op1 = a;
    op2 = b;
    go  = 1'b1;
    tick();
    go = 1'b0;
    set_strobes(13'h0);
    op1 = $urandom;
    op2 = $urandom;
    cyc = 0;
    seen = 1'b0;
    busy_first = 1'b0;
    while (!seen && cyc < 100) begin
      if (poke > 0 && cyc == poke - 1) begin
        aluSel = U_MOV;
        isMov  = 1'b1;
        op2    = 32'hDEADBEEF;
        go     = 1'b1;
      end
      tick();
      cyc++;
      if (poke > 0 && cyc == poke) begin
        go    = 1'b0;
        isMov = 1'b0;
      end
      if (cyc == 1) busy_first = busy;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (exp_lat > 1) check({tag, "_busy_running"}, 32'(busy_first), 32'd1);
    check({tag, "_result"}, result, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    go  = 1'b0;
    aluSel = 3'd0;
    set_strobes(13'h0);
    op1 = '0;
    op2 = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_result", result, 32'h0);
    check("rst_flagE", 32'(flagE), 32'd0);
    check("rst_flagGt", 32'(flagGt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_divZero", 32'(divZero), 32'd0);

    // add/sub/cmp unit
    run_op("add_wrap", U_ADD, S_ADD, 32'hFFFFFFFF, 32'h2, 32'h1, 1, 0);
    check("add_flagE", 32'(flagE), 32'd0);
    check("add_flagGt", 32'(flagGt), 32'd0);
    run_op("cmp_neg", U_ADD, S_CMP, 32'hFFFFFFFE, 32'h5, 32'h1, 1, 0);
    check("cmp_neg_E", 32'(flagE), 32'd0);
    check("cmp_neg_Gt", 32'(flagGt), 32'd0);
    run_op("cmp_eq", U_ADD, S_CMP, 32'h7, 32'h7, 32'h1, 1, 0);
    check("cmp_eq_E", 32'(flagE), 32'd1);
    check("cmp_eq_Gt", 32'(flagGt), 32'd0);
    run_op("cmp_gt", U_ADD, S_CMP, 32'h5, 32'hFFFFFFFE, 32'h1, 1, 0);
    check("cmp_gt_E", 32'(flagE), 32'd0);
    check("cmp_gt_Gt", 32'(flagGt), 32'd1);
    run_op("sub_neg", U_ADD, S_SUB, 32'h3, 32'h5, 32'hFFFFFFFE, 1, 0);
    check("sub_keeps_Gt", 32'(flagGt), 32'd1);
    run_op("add_over_sub", U_ADD, S_ADD | S_SUB | S_CMP, 32'd10, 32'd3,
           32'd13, 1, 0);
    run_op("no_strobe", U_ADD, S_MUL | S_MOV, 32'd1, 32'd1, 32'd13, 1, 0);
    run_op("reserved_sel", 3'd7, 13'h1FFF, 32'd1, 32'd1, 32'd13, 1, 0);
    check("reserved_Gt", 32'(flagGt), 32'd1);

    // multiplier
    run_op("mul_lowbits", U_MUL, S_MUL, 32'h00010000, 32'h00010001,
           32'h00010000, 33, 5);
    run_op("mul_ones", U_MUL, S_MUL, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFD,
           33, 0);

    // divider
    run_op("div_100_7", U_DIV, S_DIV, 32'd100, 32'd7, 32'd14, 33, 0);
    check("div_divZero", 32'(divZero), 32'd0);
    run_op("mod_100_7", U_DIV, S_MOD, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op("div_over_mod", U_DIV, S_DIV | S_MOD, 32'hFFFFFFFF, 32'h10,
           32'h0FFFFFFF, 33, 0);
    run_op("div_by_zero", U_DIV, S_DIV, 32'd9, 32'd0, 32'hFFFFFFFF, 1, 0);
    check("dz_div_flag", 32'(divZero), 32'd1);
    run_op("mod_by_zero", U_DIV, S_MOD, 32'd9, 32'd0, 32'd9, 1, 0);
    check("dz_mod_flag", 32'(divZero), 32'd1);

    // move / logic
    run_op("mov", U_MOV, S_MOV, 32'hAAAA5555, 32'h00001234, 32'h00001234,
           1, 0);
    check("dz_cleared", 32'(divZero), 32'd0);
    run_op("and", U_LOG, S_AND, 32'hF0F000FF, 32'hFF000F0F, 32'hF000000F,
           1, 0);
    run_op("or", U_LOG, S_OR, 32'hF0F000FF, 32'hFF000F0F, 32'hFFF00FFF,
           1, 0);
    run_op("not", U_LOG, S_NOT, 32'hF0F000FF, 32'hFF000F0F, 32'h00FFF0F0,
           1, 0);
    run_op("and_over_or", U_LOG, S_AND | S_OR | S_NOT, 32'hF0F000FF,
           32'hFF000F0F, 32'hF000000F, 1, 0);

    // shifts
    run_op("asr_neg", U_SHF, S_ASR, 32'h80000000, 32'd4, 32'hF8000000, 1, 0);
    run_op("lsr", U_SHF, S_LSR, 32'h80000000, 32'd4, 32'h08000000, 1, 0);
    run_op("lsl_amt1", U_SHF, S_LSL, 32'h80000000, 32'h21, 32'h0, 1, 0);
    run_op("lsr_amt0", U_SHF, S_LSR, 32'h12345678, 32'h20, 32'h12345678,
           1, 0);
    run_op("lsl_priority", U_SHF, S_LSL | S_LSR | S_ASR, 32'h40000001,
           32'd4, 32'h00000010, 1, 0);
    run_op("asr_pos", U_SHF, S_ASR, 32'h40000000, 32'd4, 32'h04000000, 1, 0);

    // reset in the middle of a multiply
    aluSel = U_MUL;
    set_strobes(S_MUL);
    op1 = 32'd6;
    op2 = 32'd7;
    go  = 1'b1;
    tick();
    go = 1'b0;
    set_strobes(13'h0);
    tick();
    tick();
    tick();
    check("midmul_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", result, 32'h0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_flagGt", 32'(flagGt), 32'd0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_op("post_rst_add", U_ADD, S_ADD, 32'd1, 32'd1, 32'd2, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute stage of the processor datapath. It sits directly downstream of the control unit and the register-file output latch. It consumes the control unit's `aluSel` and one-hot `is*` strobes plus two operands, and produces the result-register value and the E/Gt flags that feed back to the control unit's branch logic. Add, logic, move and shift complete in one cycle; multiply, divide and modulo run iteratively over `WIDTH` cycles under a start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; power of two, ≥ 8.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  start strobe; sampled only in IDLE.
- `aluSel`  in  3  functional unit: 0 add/sub/cmp, 1 mul, 2 div/mod, 3 mov, 4 logic, 5 shift; 6–7 reserved.
- `isAdd, isSub, isCmp, isMul, isDiv, isMod, isAnd, isOr, isNot, isMov, isLsl, isLsr, isAsr`  in  1 each  sub-operation strobes, captured with `go`.
- `op1`, `op2`  in  WIDTH  operands (register-file output data / immediate), captured with `go`.
- `result`  out  WIDTH  result register.
- `flagE`, `flagGt`  out  1  compare flags.
- `busy`  out  1  high while an iterative operation runs.
- `done`  out  1  one-cycle pulse when `result`/flags are final.
- `divZero`  out  1  set on DIV/MOD with `op2`=0; held until the next accepted `go`.

## Operation
- Reset: `result`=0, `flagE`=0, `flagGt`=0, `busy`=0, `done`=0, `divZero`=0, state IDLE. A reset mid-iteration aborts the operation with no `done` pulse.
- States:
  - IDLE: on `go`, capture operands and strobes. Sel 1 → MUL; sel 2 with `op2`≠0 → DIV; otherwise → DONE.
  - MUL / DIV: iterate `WIDTH` cycles, then → DONE.
  - DONE: assert `done` for one cycle, update outputs, then → IDLE.
- Sub-op priority when several strobes are high, within the selected unit: Add > Sub > Cmp; Div > Mod; And > Or > Not; Lsl > Lsr > Asr.
- No matching strobe, or a reserved `aluSel` value: `done` still pulses, and `result` and flags are unchanged.
- Arithmetic:
  - Add/Sub wrap modulo 2^WIDTH.
  - Cmp leaves `result` unchanged and sets `flagE` = (op1==op2) and `flagGt` = signed(op1) > signed(op2).
  - Only Cmp writes the flags.
- Mul: unsigned shift-add over WIDTH iterations; `result` = low WIDTH bits of the product.
- Div/Mod: unsigned restoring division over WIDTH iterations. Div → quotient; Mod → remainder.
- Divide by zero (`op2`=0): goes straight to DONE. `divZero`=1. Div yields all-ones; Mod yields `op1`.
- Mov: `result`=`op2`. Not: `result`=~`op2`. And/Or: bitwise on op1, op2.
- Shifts: amount = `op2[$clog2(WIDTH)-1:0]`. Asr fills with `op1[WIDTH-1]`. Amount 0 passes `op1` through.
- `go` while not in IDLE is ignored; it is not queued.
- Operands are captured, so `op1`/`op2` may change after `go` without effect.

## Timing
- Single-cycle ops: `go` sampled at edge N; `done`=1 and new `result` visible after edge N+1.
- Mul and Div/Mod (nonzero divisor): `busy` is high after edges N+1 … N+WIDTH. `done` pulses after edge N+WIDTH+1, with `busy` already low.
- Div-by-zero: same latency as single-cycle ops.
- `go` may be re-asserted in the `done` cycle; it is accepted at the next edge (back-to-back single-cycle ops: one result every 2 cycles).
- `result` holds its value between operations.

## Structure
- Shared package `alu_pkg`: `aluSel` encoding constants (`SEL_ADD`=0 … `SEL_SHIFT`=5) and the state enum (IDLE, MUL, DIV, DONE). The control unit imports the same constants.
- One sub-module: `seq_divider` (restoring divider plus iteration counter, start/done handshake).
- The multiplier iterates inline in the top level.

## Test plan
- Reset with `busy` high mid-Mul → next cycle `busy`=0, `result`=0, no `done` pulse.
- Add 0xFFFFFFFF + 2 → `result`=0x00000001 one cycle after `go`; flags unchanged.
- Cmp op1=0xFFFFFFFE (−2), op2=5 → `flagE`=0, `flagGt`=0. Then Cmp 7,7 → `flagE`=1; `result` untouched.
- Mul 0x10000 × 0x10001 → `result`=0x00010000 (low bits); `done` exactly 33 cycles after `go`. A `go` pulsed at cycle 5 is ignored.
- Div 100/7 → 14; Mod 100/7 → 2, both at 33 cycles. Div 9/0 → 0xFFFFFFFF with `divZero`=1 after 1 cycle.
- Asr 0x80000000 by 4 → 0xF8000000. Lsr by 4 → 0x08000000. Lsl with op2=0x21 (amount 1) → 0x00000000.
